// File: rtl/pc_gen_pkg.sv
// Shared definitions for the fetch PC generator.
// Holds the decoded jump opcodes from the ID decoder, the default reset vector
// and link register, the FSM state type and a helper for recognising jumps.
package pc_gen_pkg;

    // Decoded opcode values produced by the ID jump decoder.
    localparam logic [7:0] INST_INVALID = 8'h00;
    localparam logic [7:0] INST_J       = 8'h02;
    localparam logic [7:0] INST_JAL     = 8'h03;
    localparam logic [7:0] INST_JR      = 8'h08;
    localparam logic [7:0] INST_JALR    = 8'h09;

    // Default boot address and JAL link register.
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hBFC0_0000;
    localparam logic [4:0]  LINK_REG_DEFAULT     = 5'd31;

    // SEQ: sequential fetch; PEND: a jump was captured under stall.
    typedef enum logic {
        SEQ  = 1'b0,
        PEND = 1'b1
    } pc_state_t;

    function automatic logic is_jump_code(input logic [7:0] inst);
        return (inst == INST_J) || (inst == INST_JAL) ||
               (inst == INST_JR) || (inst == INST_JALR);
    endfunction

endpackage

// File: rtl/pc_gen_if.sv
// ID-to-fetch jump bus.
// master (ID decoder) drives the decoded jump fields and receives the link
// writeback request; slave (pc_gen) consumes the fields and drives the link.
//   id_valid/id_inst/id_addr/id_pc/id_rs_val/id_rd : decoded jump instruction
//   link_we/link_reg/link_data                      : JAL/JALR link writeback
interface pc_gen_if;
    logic        id_valid;
    logic [7:0]  id_inst;
    logic [25:0] id_addr;
    logic [31:0] id_pc;
    logic [31:0] id_rs_val;
    logic [4:0]  id_rd;
    logic        link_we;
    logic [4:0]  link_reg;
    logic [31:0] link_data;

    modport master (
        output id_valid, id_inst, id_addr, id_pc, id_rs_val, id_rd,
        input  link_we, link_reg, link_data
    );

    modport slave (
        input  id_valid, id_inst, id_addr, id_pc, id_rs_val, id_rd,
        output link_we, link_reg, link_data
    );
endinterface

// File: rtl/pc_gen_jump_target_calc.sv
// Combinational jump target mux and link computation.
// Ports:
//   id_*       : decoded instruction fields from ID
//   is_jump    : live instruction is one of J/JAL/JR/JALR
//   target     : redirect PC for that jump
//   link_req   : instruction wants a link write (before stall/exception gating)
//   link_reg   : link destination register
//   link_data  : id_pc + 8, 32-bit wrapping
module jump_target_calc
    import pc_gen_pkg::*;
#(
    parameter logic [4:0] LINK_REG = LINK_REG_DEFAULT
) (
    input  logic        id_valid,
    input  logic [7:0]  id_inst,
    input  logic [25:0] id_addr,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rs_val,
    input  logic [4:0]  id_rd,
    output logic        is_jump,
    output logic [31:0] target,
    output logic        link_req,
    output logic [4:0]  link_reg,
    output logic [31:0] link_data
);

    logic [31:0] pc_plus4;

    // The J-type region comes from the delay-slot address, so a jump in the
    // last word of a 256 MB region lands in the next region.
    assign pc_plus4  = id_pc + 32'd4;
    assign link_data = id_pc + 32'd8;

    // Register jumps pass rs through untouched; alignment faults are
    // detected downstream. JALR to r0 is a plain jump with no writeback.
    always_comb begin
        is_jump  = id_valid && is_jump_code(id_inst);
        target   = id_rs_val;
        link_req = 1'b0;
        link_reg = LINK_REG;
        case (id_inst)
            INST_J: begin
                target = {pc_plus4[31:28], id_addr, 2'b00};
            end
            INST_JAL: begin
                target   = {pc_plus4[31:28], id_addr, 2'b00};
                link_req = id_valid;
            end
            INST_JALR: begin
                link_req = id_valid && (id_rd != 5'd0);
                link_reg = id_rd;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/pc_gen.sv
// Fetch PC generator with MIPS delay-slot jump handling.
// Ports:
//   clk, rst_n    : clock, synchronous active-low reset
//   stall         : hold PC and the pending jump this cycle
//   exc_redirect  : exception/ERET redirect, overrides everything
//   exc_target    : redirect PC for exc_redirect
//   id_bus        : ID jump bus (slave side), carries the link writeback
//   pc            : fetch address presented to IF
//   if_delay_slot : instruction being fetched at pc is a jump delay slot
//   jump_pending  : a jump was captured under stall and is not yet applied
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [4:0]  LINK_REG     = LINK_REG_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    pc_gen_if.slave     id_bus,
    output logic [31:0] pc,
    output logic        if_delay_slot,
    output logic        jump_pending
);

    pc_state_t   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] tgt_q, tgt_d;
    logic        is_jump;
    logic [31:0] target;
    logic        link_req;

    jump_target_calc #(
        .LINK_REG (LINK_REG)
    ) u_calc (
        .id_valid  (id_bus.id_valid),
        .id_inst   (id_bus.id_inst),
        .id_addr   (id_bus.id_addr),
        .id_pc     (id_bus.id_pc),
        .id_rs_val (id_bus.id_rs_val),
        .id_rd     (id_bus.id_rd),
        .is_jump   (is_jump),
        .target    (target),
        .link_req  (link_req),
        .link_reg  (id_bus.link_reg),
        .link_data (id_bus.link_data)
    );

    // State, PC and captured target registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= SEQ;
            pc_q    <= RESET_VECTOR;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            tgt_q   <= tgt_d;
        end
    end

    // Next-state logic. In PEND the ID stage is frozen on the captured jump,
    // so its inputs are not looked at again; the exception path simply drops
    // the captured target by returning to SEQ.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        tgt_d   = tgt_q;
        if (exc_redirect) begin
            state_d = SEQ;
            pc_d    = exc_target;
        end else begin
            case (state_q)
                SEQ: begin
                    if (stall) begin
                        if (is_jump) begin
                            tgt_d   = target;
                            state_d = PEND;
                        end
                    end else if (is_jump) begin
                        pc_d = target;
                    end else begin
                        pc_d = pc_q + 32'd4;
                    end
                end
                PEND: begin
                    if (!stall) begin
                        pc_d    = tgt_q;
                        state_d = SEQ;
                    end
                end
                default: begin
                    state_d = SEQ;
                end
            endcase
        end
    end

    // Outputs. The delay-slot tag marks the cycle in which a jump advances
    // out of ID, either directly or on release of a pending capture.
    always_comb begin
        pc             = pc_q;
        jump_pending   = (state_q == PEND);
        if_delay_slot  = rst_n && !exc_redirect && !stall &&
                         ((state_q == PEND) || is_jump);
        id_bus.link_we = rst_n && !exc_redirect && !stall && link_req;
    end

endmodule
